// File: rtl/axi2mem_sched_pkg.sv
// Shared constants for the axi2mem TCDM sequencer: FSM encodings and lane geometry.
package axi2mem_sched_pkg;

  localparam int unsigned NB_LANES   = 2;
  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned LANE_BYTES = 4;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t StIdle  = 2'd0;
  localparam sched_state_t StRead  = 2'd1;
  localparam sched_state_t StWrite = 2'd2;

endpackage

// File: rtl/axi2mem_lane_issue.sv
// One TCDM lane within a beat: holds req until granted, remembers completion,
// and captures the read tag {id, last} at grant time.
module axi2mem_lane_issue #(
  parameter int unsigned ID_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en,
  input  logic                gnt,
  input  logic                clear,
  input  logic                capture,
  input  logic [ID_WIDTH-1:0] id,
  input  logic                last,
  output logic                req,
  output logic                done,
  output logic [ID_WIDTH-1:0] tag_id,
  output logic                tag_last
);

  logic done_q;
  logic fire;

  assign req  = issue_en & ~done_q;
  assign fire = req & gnt;
  // Includes a grant landing this cycle so the beat can close without a bubble.
  assign done = done_q | fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      tag_id   <= '0;
      tag_last <= 1'b0;
    end else begin
      done_q <= clear ? 1'b0 : done;
      if (capture && fire) begin
        tag_id   <= id;
        tag_last <= last;
      end
    end
  end

endmodule

// File: rtl/axi2mem_tcdm_sched.sv
// Read/write burst sequencer for the 2x32-bit TCDM datapath: round-robin command
// arbitration, beat-to-lane splitting, read credit throttling and write-buffer pops.
module axi2mem_tcdm_sched
  import axi2mem_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned RD_CREDITS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_cmd_valid_i,
  output logic                    rd_cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    rd_cmd_len_i,
  input  logic [ID_WIDTH-1:0]     rd_cmd_id_i,
  input  logic                    wr_cmd_valid_i,
  output logic                    wr_cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    wr_cmd_len_i,
  input  logic [ID_WIDTH-1:0]     wr_cmd_id_i,
  input  logic [1:0]              wr_data_valid_i,
  output logic [1:0]              wr_data_pop_o,
  output logic [1:0]              tcdm_req_o,
  output logic [2*ADDR_WIDTH-1:0] tcdm_add_o,
  output logic [1:0]              tcdm_wen_o,
  input  logic [1:0]              tcdm_gnt_i,
  input  logic [1:0]              tcdm_r_valid_i,
  output logic [ID_WIDTH-1:0]     rd_push_id_o,
  output logic                    rd_push_last_o,
  input  logic                    rd_credit_ret_i,
  output logic                    wr_done_o,
  output logic [ID_WIDTH-1:0]     wr_done_id_o,
  output logic                    busy_o
);

  localparam int unsigned CW = $clog2(RD_CREDITS + 1);

  sched_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  prio_q, prio_d;       // 0: read holds priority
  logic                  started_q, started_d; // current read beat already owns a credit

  logic                  in_idle, in_read, in_write;
  logic                  read_go, reserve, complete, last_beat;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [NB_LANES-1:0]   issue_en, lane_req, lane_done, lane_tag_last;
  logic [ID_WIDTH-1:0]   lane_tag_id [NB_LANES];

  assign in_idle   = (state_q == StIdle);
  assign in_read   = (state_q == StRead);
  assign in_write  = (state_q == StWrite);
  assign busy_o    = ~in_idle;
  assign last_beat = (beat_q == len_q);
  assign beat_addr = addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES);

  assign read_go  = in_read & (started_q | (credits_q != '0));
  assign reserve  = in_read & ~started_q & (credits_q != '0);
  assign issue_en = {NB_LANES{read_go}} | ({NB_LANES{in_write}} & wr_data_valid_i);
  assign complete = (in_read | in_write) & (&lane_done);

  assign rd_cmd_ready_o = in_idle & rd_cmd_valid_i & (~wr_cmd_valid_i | ~prio_q);
  assign wr_cmd_ready_o = in_idle & wr_cmd_valid_i & (~rd_cmd_valid_i | prio_q);

  for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
    axi2mem_lane_issue #(
      .ID_WIDTH(ID_WIDTH)
    ) u_lane (
      .clk      (clk_i),
      .rst      (rst_i),
      .issue_en (issue_en[i]),
      .gnt      (tcdm_gnt_i[i]),
      .clear    (complete),
      .capture  (in_read),
      .id       (id_q),
      .last     (last_beat),
      .req      (lane_req[i]),
      .done     (lane_done[i]),
      .tag_id   (lane_tag_id[i]),
      .tag_last (lane_tag_last[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    beat_d    = beat_q;
    prio_d    = prio_q;
    started_d = started_q;
    if (in_idle) begin
      // Priority only rotates when both sides actually contended.
      if (rd_cmd_valid_i && wr_cmd_valid_i) prio_d = ~prio_q;
      if (rd_cmd_ready_o) begin
        state_d = StRead;
        addr_d  = {rd_cmd_addr_i[ADDR_WIDTH-1:3], 3'b000};
        len_d   = rd_cmd_len_i;
        id_d    = rd_cmd_id_i;
        beat_d  = '0;
      end else if (wr_cmd_ready_o) begin
        state_d = StWrite;
        addr_d  = {wr_cmd_addr_i[ADDR_WIDTH-1:3], 3'b000};
        len_d   = wr_cmd_len_i;
        id_d    = wr_cmd_id_i;
        beat_d  = '0;
      end
    end else if (complete) begin
      started_d = 1'b0;
      if (last_beat) begin
        state_d = StIdle;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + LEN_WIDTH'(1);
      end
    end else begin
      started_d = started_q | reserve;
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (reserve && !rd_credit_ret_i) begin
      credits_d = credits_q - CW'(1);
    end else if (!reserve && rd_credit_ret_i && (credits_q < CW'(RD_CREDITS))) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      beat_q    <= '0;
      credits_q <= CW'(RD_CREDITS);
      prio_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      beat_q    <= beat_d;
      credits_q <= credits_d;
      prio_q    <= prio_d;
      started_q <= started_d;
    end
  end

  assign tcdm_req_o    = lane_req;
  assign tcdm_wen_o    = {NB_LANES{in_read}};
  assign wr_data_pop_o = {NB_LANES{in_write}} & lane_req & tcdm_gnt_i;
  assign wr_done_o     = in_write & complete & last_beat;
  assign wr_done_id_o  = wr_done_o ? id_q : '0;

  always_comb begin
    tcdm_add_o = '0;
    if (busy_o) begin
      tcdm_add_o[ADDR_WIDTH-1:0]            = beat_addr;
      tcdm_add_o[2*ADDR_WIDTH-1:ADDR_WIDTH] = beat_addr + ADDR_WIDTH'(LANE_BYTES);
    end
  end

  always_comb begin
    rd_push_id_o   = '0;
    rd_push_last_o = 1'b0;
    if (tcdm_r_valid_i[0]) begin
      rd_push_id_o   = lane_tag_id[0];
      rd_push_last_o = lane_tag_last[0];
    end else if (tcdm_r_valid_i[1]) begin
      rd_push_id_o   = lane_tag_id[1];
      rd_push_last_o = lane_tag_last[1];
    end
  end

endmodule

// File: tb/tb_axi2mem_tcdm_sched.sv
// Bench for axi2mem_tcdm_sched: a TCDM slave model with per-lane grant delay,
// scoreboard queues of expected lane accesses, read tags and write completions.
module tb_axi2mem_tcdm_sched;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rd_cmd_valid_i, rd_cmd_ready_o;
  logic [31:0] rd_cmd_addr_i;
  logic [7:0]  rd_cmd_len_i;
  logic [5:0]  rd_cmd_id_i;
  logic        wr_cmd_valid_i, wr_cmd_ready_o;
  logic [31:0] wr_cmd_addr_i;
  logic [7:0]  wr_cmd_len_i;
  logic [5:0]  wr_cmd_id_i;
  logic [1:0]  wr_data_valid_i, wr_data_pop_o;
  logic [1:0]  tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [63:0] tcdm_add_o;
  logic [5:0]  rd_push_id_o, wr_done_id_o;
  logic        rd_push_last_o, rd_credit_ret_i, wr_done_o, busy_o;

  logic credit_auto, credit_pulse;
  assign rd_credit_ret_i = credit_auto | credit_pulse;

  always #5 clk = ~clk;

  axi2mem_tcdm_sched dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .rd_cmd_valid_i  (rd_cmd_valid_i),
    .rd_cmd_ready_o  (rd_cmd_ready_o),
    .rd_cmd_addr_i   (rd_cmd_addr_i),
    .rd_cmd_len_i    (rd_cmd_len_i),
    .rd_cmd_id_i     (rd_cmd_id_i),
    .wr_cmd_valid_i  (wr_cmd_valid_i),
    .wr_cmd_ready_o  (wr_cmd_ready_o),
    .wr_cmd_addr_i   (wr_cmd_addr_i),
    .wr_cmd_len_i    (wr_cmd_len_i),
    .wr_cmd_id_i     (wr_cmd_id_i),
    .wr_data_valid_i (wr_data_valid_i),
    .wr_data_pop_o   (wr_data_pop_o),
    .tcdm_req_o      (tcdm_req_o),
    .tcdm_add_o      (tcdm_add_o),
    .tcdm_wen_o      (tcdm_wen_o),
    .tcdm_gnt_i      (tcdm_gnt_i),
    .tcdm_r_valid_i  (tcdm_r_valid_i),
    .rd_push_id_o    (rd_push_id_o),
    .rd_push_last_o  (rd_push_last_o),
    .rd_credit_ret_i (rd_credit_ret_i),
    .wr_done_o       (wr_done_o),
    .wr_done_id_o    (wr_done_id_o),
    .busy_o          (busy_o)
  );

  typedef struct packed {logic [31:0] addr; logic wen;} acc_t;
  typedef struct packed {logic [5:0] id; logic last;} tag_t;

  acc_t       q_lane0[$];
  acc_t       q_lane1[$];
  tag_t       q_tag[$];
  logic [5:0] q_done[$];

  int vectors = 0;
  int miscompares = 0;
  int req_cnt[2], grant_cnt[2], pop_cnt[2];
  int done_cnt = 0;
  int unsigned gnt_delay[2], wait_cnt[2];
  logic [1:0] rv_next = '0;

  // Monitor-private temporaries.
  logic [1:0] mon_gnt, mon_pop;
  acc_t       mon_acc;
  tag_t       mon_tag;
  logic [5:0] mon_id;
  bit         mon_has;

  function automatic void push_burst(input bit is_wr, input logic [31:0] addr, input int len,
                                     input logic [5:0] id);
    logic [31:0] base;
    acc_t e;
    tag_t t;
    base = addr & 32'hFFFF_FFF8;
    for (int b = 0; b <= len; b++) begin
      e.addr = base + 32'(b * 8);
      e.wen  = !is_wr;
      q_lane0.push_back(e);
      e.addr = e.addr + 32'd4;
      q_lane1.push_back(e);
      if (!is_wr) begin
        t.id   = id;
        t.last = (b == len);
        q_tag.push_back(t);
      end
    end
    if (is_wr) q_done.push_back(id);
  endfunction

  // TCDM slave + scoreboard: r_valid at +1, grants at +6, sampling at +8 after posedge.
  always begin
    @(posedge clk);
    #1;
    tcdm_r_valid_i = rv_next;
    rv_next = '0;
    #5;
    for (int i = 0; i < 2; i++) begin
      if (rst_i || !tcdm_req_o[i]) begin
        mon_gnt[i] = 1'b0;
        if (rst_i) wait_cnt[i] = 0;
      end else if (wait_cnt[i] < gnt_delay[i]) begin
        mon_gnt[i] = 1'b0;
        wait_cnt[i]++;
      end else begin
        mon_gnt[i] = 1'b1;
        wait_cnt[i] = 0;
      end
    end
    tcdm_gnt_i = mon_gnt;
    #2;
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        if (tcdm_req_o[i]) req_cnt[i]++;
        if (wr_data_pop_o[i]) pop_cnt[i]++;
        if (tcdm_req_o[i] && tcdm_gnt_i[i]) begin
          grant_cnt[i]++;
          vectors++;
          mon_has = (i == 0) ? (q_lane0.size() > 0) : (q_lane1.size() > 0);
          if (!mon_has) begin
            miscompares++;
            $display("FAIL lane%0d access: unexpected grant addr=%h wen=%b", i,
                     tcdm_add_o[i*32 +: 32], tcdm_wen_o[i]);
          end else begin
            if (i == 0) mon_acc = q_lane0.pop_front();
            else mon_acc = q_lane1.pop_front();
            if ({tcdm_add_o[i*32 +: 32], tcdm_wen_o[i]} !== {mon_acc.addr, mon_acc.wen}) begin
              miscompares++;
              $display("FAIL lane%0d access: got addr=%h wen=%b, want addr=%h wen=%b", i,
                       tcdm_add_o[i*32 +: 32], tcdm_wen_o[i], mon_acc.addr, mon_acc.wen);
            end
          end
          if (tcdm_wen_o[i]) rv_next[i] = 1'b1;
        end
      end
      if (|tcdm_req_o || |wr_data_pop_o) begin
        mon_pop = tcdm_req_o & tcdm_gnt_i & ~tcdm_wen_o;
        vectors++;
        if (wr_data_pop_o !== mon_pop) begin
          miscompares++;
          $display("FAIL write pop: got %b want %b", wr_data_pop_o, mon_pop);
        end
      end
      if (tcdm_r_valid_i[0]) begin
        vectors++;
        if (q_tag.size() == 0) begin
          miscompares++;
          $display("FAIL read tag: unexpected r_valid id=%h last=%b", rd_push_id_o, rd_push_last_o);
        end else begin
          mon_tag = q_tag.pop_front();
          if ({rd_push_id_o, rd_push_last_o} !== {mon_tag.id, mon_tag.last}) begin
            miscompares++;
            $display("FAIL read tag: got id=%h last=%b want id=%h last=%b", rd_push_id_o,
                     rd_push_last_o, mon_tag.id, mon_tag.last);
          end
        end
      end
      if (wr_done_o) begin
        done_cnt++;
        vectors++;
        if (q_done.size() == 0) begin
          miscompares++;
          $display("FAIL write done: unexpected pulse id=%h", wr_done_id_o);
        end else begin
          mon_id = q_done.pop_front();
          if (wr_done_id_o !== mon_id) begin
            miscompares++;
            $display("FAIL write done: got id=%h want id=%h", wr_done_id_o, mon_id);
          end
        end
      end
    end else begin
      rv_next = '0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    rd_cmd_valid_i = 1'b0;
    wr_cmd_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q_lane0.delete();
    q_lane1.delete();
    q_tag.delete();
    q_done.delete();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic send_cmd(input bit is_wr, input logic [31:0] addr, input int len,
                          input logic [5:0] id, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (is_wr) begin
      wr_cmd_valid_i = 1'b1; wr_cmd_addr_i = addr; wr_cmd_len_i = 8'(len); wr_cmd_id_i = id;
    end else begin
      rd_cmd_valid_i = 1'b1; rd_cmd_addr_i = addr; rd_cmd_len_i = 8'(len); rd_cmd_id_i = id;
    end
    for (int k = 0; k < 200 && !ok; k++) begin
      #3;
      if ((is_wr ? wr_cmd_ready_o : rd_cmd_ready_o) === 1'b1) begin
        ok = 1'b1;
        push_burst(is_wr, addr, len, id);
      end
      @(negedge clk);
    end
    rd_cmd_valid_i = 1'b0;
    wr_cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      #4;
      if (!busy_o && q_lane0.size() == 0 && q_lane1.size() == 0 && q_tag.size() == 0 &&
          q_done.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    vectors++;
    if ({busy_o, tcdm_req_o, wr_data_pop_o, wr_done_o, rd_cmd_ready_o, wr_cmd_ready_o,
         tcdm_wen_o} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset outputs: got busy=%b req=%b pop=%b done=%b rdy=%b%b wen=%b want all 0",
               busy_o, tcdm_req_o, wr_data_pop_o, wr_done_o, rd_cmd_ready_o, wr_cmd_ready_o,
               tcdm_wen_o);
    end
    vectors++;
    if ({tcdm_add_o, rd_push_id_o, rd_push_last_o, wr_done_id_o} !== 77'b0) begin
      miscompares++;
      $display("FAIL reset values: got add=%h push=%h/%b done_id=%h want 0", tcdm_add_o,
               rd_push_id_o, rd_push_last_o, wr_done_id_o);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int cnt;
    credit_auto = 1'b1;
    send_cmd(1'b0, 32'h1000, 3, 6'd5, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL single read accept: got 0 want 1"); end
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      #3;
      if (busy_o) cnt++;
      else break;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 4) begin
      miscompares++;
      $display("FAIL single read duration: got %0d busy cycles want 4", cnt);
    end
    wait_drain(ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL single read drain: got 0 want 1"); end
  endtask

  task automatic test_credit_throttle();
    bit ok;
    int g0, g1;
    credit_auto = 1'b0;
    g0 = grant_cnt[0];
    g1 = grant_cnt[1];
    send_cmd(1'b0, 32'h2000, 7, 6'd9, ok);
    repeat (8) @(negedge clk);
    #4;
    vectors++;
    if (ok !== 1'b1 || grant_cnt[0] - g0 != 2 || grant_cnt[1] - g1 != 2) begin
      miscompares++;
      $display("FAIL credit stall beats: got ok=%b %0d/%0d want 1 2/2", ok, grant_cnt[0] - g0,
               grant_cnt[1] - g1);
    end
    vectors++;
    if (tcdm_req_o !== 2'b00 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL credit stall req: got req=%b busy=%b want 00 1", tcdm_req_o, busy_o);
    end
    @(negedge clk);
    credit_pulse = 1'b1;
    @(negedge clk);
    credit_pulse = 1'b0;
    repeat (6) @(negedge clk);
    #4;
    vectors++;
    if (grant_cnt[0] - g0 != 3 || grant_cnt[1] - g1 != 3 || tcdm_req_o !== 2'b00) begin
      miscompares++;
      $display("FAIL credit return beat: got %0d/%0d req=%b want 3/3 00", grant_cnt[0] - g0,
               grant_cnt[1] - g1, tcdm_req_o);
    end
    credit_auto = 1'b1;
    wait_drain(ok);
    vectors++;
    if (ok !== 1'b1 || grant_cnt[0] - g0 != 8) begin
      miscompares++;
      $display("FAIL credit drain: got ok=%b beats=%0d want 1 8", ok, grant_cnt[0] - g0);
    end
  endtask

  task automatic test_write_skew();
    bit ok;
    int r0, r1, p0, p1, d;
    r0 = req_cnt[0]; r1 = req_cnt[1]; p0 = pop_cnt[0]; p1 = pop_cnt[1]; d = done_cnt;
    gnt_delay[1] = 3;
    send_cmd(1'b1, 32'h20, 1, 6'h2A, ok);
    wait_drain(ok);
    gnt_delay[1] = 0;
    vectors++;
    if (ok !== 1'b1 || req_cnt[0] - r0 != 2 || req_cnt[1] - r1 != 8) begin
      miscompares++;
      $display("FAIL skew req cycles: got ok=%b %0d/%0d want 1 2/8", ok, req_cnt[0] - r0,
               req_cnt[1] - r1);
    end
    vectors++;
    if (pop_cnt[0] - p0 != 2 || pop_cnt[1] - p1 != 2 || done_cnt - d != 1) begin
      miscompares++;
      $display("FAIL skew pops/done: got %0d/%0d done=%0d want 2/2 1", pop_cnt[0] - p0,
               pop_cnt[1] - p1, done_cnt - d);
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      rd_cmd_valid_i = 1'b1; rd_cmd_addr_i = 32'h300 + 32'(round * 'h200);
      rd_cmd_len_i = 8'd0;   rd_cmd_id_i = 6'(1 + round * 2);
      wr_cmd_valid_i = 1'b1; wr_cmd_addr_i = 32'h400 + 32'(round * 'h200);
      wr_cmd_len_i = 8'd0;   wr_cmd_id_i = 6'(2 + round * 2);
      #3;
      vectors++;
      if ({rd_cmd_ready_o, wr_cmd_ready_o} !== ((round == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL arbitration round%0d: got rd/wr ready=%b%b want %s", round,
                 rd_cmd_ready_o, wr_cmd_ready_o, (round == 0) ? "10" : "01");
      end
      if (round == 0) push_burst(1'b0, rd_cmd_addr_i, 0, rd_cmd_id_i);
      else push_burst(1'b1, wr_cmd_addr_i, 0, wr_cmd_id_i);
      @(negedge clk);
      if (round == 0) rd_cmd_valid_i = 1'b0;
      else wr_cmd_valid_i = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        #3;
        if (((round == 0) ? wr_cmd_ready_o : rd_cmd_ready_o) === 1'b1) ok = 1'b1;
        else @(negedge clk);
      end
      vectors++;
      if (ok !== 1'b1 || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL arbitration second accept: got ok=%b busy=%b want 1 0", ok, busy_o);
      end
      if (round == 0) push_burst(1'b1, wr_cmd_addr_i, 0, wr_cmd_id_i);
      else push_burst(1'b0, rd_cmd_addr_i, 0, rd_cmd_id_i);
      @(negedge clk);
      rd_cmd_valid_i = 1'b0;
      wr_cmd_valid_i = 1'b0;
      wait_drain(ok);
      vectors++;
      if (ok !== 1'b1) begin miscompares++; $display("FAIL arbitration drain: got 0 want 1"); end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    send_cmd(1'b0, 32'hFFFF_FFFB, 1, 6'd3, ok);
    wait_drain(ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL wrap drain: got 0 want 1"); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int d, g0;
    send_cmd(1'b1, 32'h100, 7, 6'h11, ok);
    repeat (2) @(negedge clk);
    #3;
    vectors++;
    if (ok !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid-burst busy: got ok=%b busy=%b want 1 1", ok, busy_o);
    end
    d = done_cnt;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    q_lane0.delete(); q_lane1.delete(); q_tag.delete(); q_done.delete();
    @(negedge clk);
    #3;
    vectors++;
    if ({tcdm_req_o, wr_data_pop_o, wr_done_o, busy_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL mid-burst reset: got req=%b pop=%b done=%b busy=%b want 0", tcdm_req_o,
               wr_data_pop_o, wr_done_o, busy_o);
    end
    rst_i = 1'b0;
    credit_auto = 1'b0;
    g0 = grant_cnt[0];
    send_cmd(1'b0, 32'h40, 1, 6'h22, ok);
    wait_drain(ok);
    credit_auto = 1'b1;
    vectors++;
    if (ok !== 1'b1 || grant_cnt[0] - g0 != 2 || done_cnt != d) begin
      miscompares++;
      $display("FAIL post-reset read: got ok=%b beats=%0d extra_done=%0d want 1 2 0", ok,
               grant_cnt[0] - g0, done_cnt - d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    rd_cmd_valid_i = 1'b0; rd_cmd_addr_i = '0; rd_cmd_len_i = '0; rd_cmd_id_i = '0;
    wr_cmd_valid_i = 1'b0; wr_cmd_addr_i = '0; wr_cmd_len_i = '0; wr_cmd_id_i = '0;
    wr_data_valid_i = 2'b11;
    tcdm_gnt_i = '0;
    tcdm_r_valid_i = '0;
    credit_auto = 1'b1;
    credit_pulse = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_cnt[i] = 0; grant_cnt[i] = 0; pop_cnt[i] = 0; gnt_delay[i] = 0; wait_cnt[i] = 0;
    end
    test_reset();
    test_single_read();
    test_credit_throttle();
    test_write_skew();
    test_arbitration();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi2mem_tcdm_sched.md
Name: axi2mem_tcdm_sched

Overview:
- Sequencer and arbiter for the axi2mem 2x32-bit TCDM datapath.
- Accepts AXI-derived read and write burst commands and round-robin arbitrates between them.
- Splits each 64-bit beat into two 32-bit TCDM lane accesses and drives lane requests and addresses.
- Throttles reads against read-buffer credits, tags returning read data with ID/last, and pops the write buffers.

Parameters:
- ADDR_WIDTH, 32, TCDM/AXI byte address width
- ID_WIDTH, 6, AXI transaction ID width
- LEN_WIDTH, 8, burst length field (beats-1)
- RD_CREDITS, 2, read-buffer depth per lane (beats)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- rd_cmd_valid_i  in  1  read burst command valid
- rd_cmd_ready_o  out  1  read command accepted
- rd_cmd_addr_i  in  ADDR_WIDTH  burst start byte address
- rd_cmd_len_i  in  LEN_WIDTH  beats-1
- rd_cmd_id_i  in  ID_WIDTH  AXI ID
- wr_cmd_valid_i  in  1  write burst command valid
- wr_cmd_ready_o  out  1  write command accepted
- wr_cmd_addr_i  in  ADDR_WIDTH  start address
- wr_cmd_len_i  in  LEN_WIDTH  beats-1
- wr_cmd_id_i  in  ID_WIDTH  AXI ID
- wr_data_valid_i  in  2  per-lane write-buffer non-empty
- wr_data_pop_o  out  2  per-lane write-buffer pop
- tcdm_req_o  out  2  per-lane TCDM request
- tcdm_add_o  out  2xADDR_WIDTH  per-lane address
- tcdm_wen_o  out  2  1=read, 0=write
- tcdm_gnt_i  in  1 per lane (2)  per-lane grant
- tcdm_r_valid_i  in  2  per-lane read data valid (1 cycle after gnt)
- rd_push_id_o  out  ID_WIDTH  ID accompanying read-data push
- rd_push_last_o  out  1  last beat flag accompanying push
- rd_credit_ret_i  in  1  one 64-bit beat popped from read buffer
- wr_done_o  out  1  one-cycle pulse, write burst fully issued
- wr_done_id_o  out  ID_WIDTH  ID of completed write
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset values: all outputs 0. FSM=IDLE, credits=RD_CREDITS, rr priority=read, beat counter=0.
- FSM states: IDLE, READ, WRITE.
- IDLE, arbitration:
  - Only one valid: that command's ready=1 (combinational).
  - Both valid: priority holder gets ready; priority flips to the other after each accept.
  - Accept (valid&ready) latches addr with [2:0] forced 0, plus len and id; next state READ or WRITE.
- Beat address: base+8*beat, modulo 2^ADDR_WIDTH (wraps, no 4KB check). Lane0 = beat address, lane1 = beat address+4.
- Lanes issue independently within a beat:
  - Each lane holds a done flag set on req&gnt.
  - Req stays asserted until granted, address stable meanwhile.
  - Beat completes in the cycle both lanes are done, or become done. Flags then clear and the counter increments, with no idle cycle between beats.
- READ:
  - A beat may start only if credits>0. The credit is reserved (decremented) in the beat's first issue cycle.
  - rd_credit_ret_i increments credits. Simultaneous reserve+return leaves credits unchanged.
  - Credits never exceed RD_CREDITS or go below 0; a return at full credits is an error and is ignored.
  - At each lane gnt, capture {id, beat==len} into that lane's 1-deep register, presented on rd_push_id_o/rd_push_last_o while lane0 r_valid.
  - After the last beat completes -> IDLE; trailing r_valid is still tagged correctly.
- WRITE:
  - Lane i req only while wr_data_valid_i[i]; tcdm_wen_o=0.
  - wr_data_pop_o[i]=tcdm_req_o[i]&tcdm_gnt_i[i].
  - On last beat complete: wr_done_o=1 for one cycle with wr_done_id_o, then -> IDLE.
- Commands are not accepted before return to IDLE, giving a minimum one-cycle gap between bursts.
- len=0 gives a single beat with last=1.
- Reset mid-burst: immediate return to reset values; no pops or done pulse are issued.

Decomposition:
- Package axi2mem_sched_pkg: state enum (IDLE/READ/WRITE), NB_LANES=2, BEAT_BYTES=8, LANE_BYTES=4.
- Sub-module axi2mem_lane_issue, instanced twice: per-lane done flag, req gating, and ID/last capture register.

Test Plan:
- Single read, addr 0x1000, len 3, id 5, credits returned every cycle:
  - Lane addrs 0x1000/0x1004 through 0x1018/0x101C, 4 beats in 4 cycles.
  - last=1 only on 4th r_valid, id=5 throughout; then IDLE.
- Read len 7 with no credit return:
  - Exactly 2 beats issued, then req stays 0.
  - One rd_credit_ret_i pulse -> exactly one more beat.
- Lane skew during write, addr 0x20 len 1:
  - Lane1 gnt delayed 3 cycles; lane0 req drops after its gnt and waits for the next beat.
  - 2 pops per lane, wr_done_o one pulse with correct ID.
- Read and write valid together in IDLE from reset: read accepted first, write next.
  - Repeat with both valid: write first (priority flipped).
- Unaligned addr 0xFFFFFFFB, len 1:
  - Addrs 0xFFFFFFF8/0xFFFFFFFC, then 0x0/0x4 (wrap).
- rst_i asserted mid-write-burst: next cycle all req/pop/done 0, busy_o=0, credits=RD_CREDITS; a new read accepted normally.
